// File: rtl/if_id_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_stage_if : instruction-memory request/acknowledge bus                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface if_id_stage_if #(
    parameter int N = 64
) ();
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_stage : LEGv8 fetch stage with IF/ID register, skid and redirect     |
// | Optional load-use stall: define IF_ID_LOAD_USE_STALL_EN.  Rev 1.0          |
// +----------------------------------------------------------------------------+
module if_id_stage #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  wire              clk,
    input  wire              reset,
    if_id_stage_if.master    imem,
    input  wire              stall_D,
    input  wire              PCSrc_M,
    input  wire  [N-1:0]     PCBranch_M,
    input  wire              MemRead_E,
    input  wire  [4:0]       rd_E,
    output logic [31:0]      instr_D,
    output logic [N-1:0]     pc_D,
    output logic             valid_D,
    output logic [10:0]      Op_D,
    output logic             ld_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_req;
    logic [N-1:0] r_fa;
    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic [N-1:0] r_pc_D;
    logic         r_valid;
    logic [31:0]  r_skid_instr;
    logic [N-1:0] r_skid_pc;

    logic         w_stall;
    logic [N-1:0] w_fa_inc;

    assign w_stall  = stall_D | ld_stall;
    assign w_fa_inc = r_fa + N'(4);

`ifdef IF_ID_LOAD_USE_STALL_EN
    // Conservative: every register field is compared, whatever the format.
    assign ld_stall = MemRead_E & r_valid & (rd_E != 5'd31) &
                      ((rd_E == r_instr[9:5])  |
                       (rd_E == r_instr[20:16]) |
                       (rd_E == r_instr[4:0]));
`else
    logic w_unused_ex;
    assign w_unused_ex = ^{MemRead_E, rd_E};
    assign ld_stall    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_fa         <= RESET_PC;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_pc_D       <= '0;
            r_valid      <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_fa    <= r_pc;
                end
                S_REQ: begin
                    if (PCSrc_M) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        r_pc    <= PCBranch_M;
                        if (imem.imem_ack) begin
                            r_fa <= PCBranch_M;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end else if (imem.imem_ack) begin
                        r_pc <= w_fa_inc;
                        if (!w_stall) begin
                            r_instr <= imem.imem_rdata;
                            r_pc_D  <= r_fa;
                            r_valid <= 1'b1;
                            r_fa    <= w_fa_inc;
                        end else begin
                            r_skid_instr <= imem.imem_rdata;
                            r_skid_pc    <= r_fa;
                            r_state      <= S_HOLD;
                            r_req        <= 1'b0;
                        end
                    end else if (!w_stall) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                    end
                end
                S_HOLD: begin
                    if (PCSrc_M) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        r_pc    <= PCBranch_M;
                        r_fa    <= PCBranch_M;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end else if (!w_stall) begin
                        r_instr <= r_skid_instr;
                        r_pc_D  <= r_skid_pc;
                        r_valid <= 1'b1;
                        r_fa    <= r_pc;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_DROP: begin
                    // Stale response is thrown away; a late redirect only moves pc.
                    if (!w_stall) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                    end
                    if (PCSrc_M) begin
                        r_pc <= PCBranch_M;
                    end
                    if (imem.imem_ack) begin
                        r_state <= S_REQ;
                        r_fa    <= PCSrc_M ? PCBranch_M : r_pc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_fa;
    assign instr_D        = r_instr;
    assign pc_D           = r_pc_D;
    assign valid_D        = r_valid;
    assign Op_D           = r_instr[31:21];

endmodule
`default_nettype wire
